// File: rtl/tmr_voter_pkg.sv
// tmr_voter_pkg: shared voter types, blame encodings and saturating increment for the TMR word voter.
package tmr_voter_pkg;
  typedef enum logic [1:0] {CLASSICAL, KP, BN} voter_type_e;
  localparam logic [2:0] BLAME_NONE = 3'b000;
  localparam logic [2:0] BLAME_A    = 3'b001;
  localparam logic [2:0] BLAME_B    = 3'b010;
  localparam logic [2:0] BLAME_C    = 3'b100;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/tmr_word_vote.sv
// tmr_word_vote: per-bit majority voter plus word comparators giving fault, blame and multi-fault.
module tmr_word_vote
  import tmr_voter_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int VoterType = 1
) (
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  input  logic [DataWidth-1:0] c,
  output logic [DataWidth-1:0] data,
  output logic                 fault,
  output logic [2:0]           blame,
  output logic                 multi_fault
);
  logic ab, ac, bc;
  for (genvar i = 0; i < DataWidth; i++) begin : g_bit
    if (VoterType == int'(CLASSICAL)) begin : g_cl
      assign data[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end else if (VoterType == int'(KP)) begin : g_kp
      assign data[i] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end else begin : g_bn
      assign data[i] = (a[i] ^ b[i]) ? c[i] : a[i];
    end
  end
  assign ab = a != b;
  assign ac = a != c;
  assign bc = b != c;
  assign fault = ab | bc;
  assign multi_fault = ab & ac & bc;
  assign blame = (ab & ac & !bc) ? BLAME_A :
                 (ab & !ac & bc) ? BLAME_B :
                 (!ab & ac & bc) ? BLAME_C : BLAME_NONE;
endmodule

// File: rtl/tmr_word_voter_monitor.sv
// tmr_word_voter_monitor: TMR word voter with per-replica saturating error counters and sticky alarm.
// Define TMR_WORD_VOTER_OUT_REG_EN to register data/valid/fault/blame/multi_fault outputs (latency 1).
module tmr_word_voter_monitor
  import tmr_voter_pkg::*;
#(
  parameter int DataWidth      = 32,
  parameter int VoterType      = 1,
  parameter int CntWidth       = 8,
  parameter int AlarmThreshold = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] c_i,
  input  logic                 clear_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  output logic                 fault_o,
  output logic [2:0]           blame_o,
  output logic                 multi_fault_o,
  output logic [CntWidth-1:0]  cnt_a_o,
  output logic [CntWidth-1:0]  cnt_b_o,
  output logic [CntWidth-1:0]  cnt_c_o,
  output logic [CntWidth-1:0]  cnt_multi_o,
  output logic                 alarm_o
);
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] Thr = CntWidth'(AlarmThreshold);
  if (DataWidth < 1) begin : g_bad_dw
    $fatal(1, "DataWidth must be >= 1");
  end
  if (VoterType < 0 || VoterType > 2) begin : g_bad_vt
    $fatal(1, "VoterType must be 0, 1 or 2");
  end
  if (CntWidth < 2 || CntWidth > 32) begin : g_bad_cw
    $fatal(1, "CntWidth must be in 2..32");
  end
  if (AlarmThreshold < 1 || longint'(AlarmThreshold) > (longint'(1) << CntWidth) - 1) begin : g_bad_thr
    $fatal(1, "AlarmThreshold must be in 1..2^CntWidth-1");
  end
  function automatic logic [CntWidth-1:0] inc(input logic [CntWidth-1:0] v);
    return CntWidth'(sat_inc(32'(v), 32'(CntMax)));
  endfunction
  logic [DataWidth-1:0] v_data;
  logic                 v_fault, v_multi;
  logic [2:0]           v_blame;
  logic                 hit;
  tmr_word_vote #(.DataWidth(DataWidth), .VoterType(VoterType)) u_vote (
    .a(a_i), .b(b_i), .c(c_i),
    .data(v_data), .fault(v_fault), .blame(v_blame), .multi_fault(v_multi)
  );
  assign hit = (cnt_a_o >= Thr) | (cnt_b_o >= Thr) | (cnt_c_o >= Thr) | (cnt_multi_o >= Thr);
  // Clear wins over a same-cycle event, so the event is simply not counted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_a_o     <= '0;
      cnt_b_o     <= '0;
      cnt_c_o     <= '0;
      cnt_multi_o <= '0;
      alarm_o     <= 1'b0;
    end else if (clear_i) begin
      cnt_a_o     <= '0;
      cnt_b_o     <= '0;
      cnt_c_o     <= '0;
      cnt_multi_o <= '0;
      alarm_o     <= 1'b0;
    end else begin
      if (valid_i && v_blame[0]) cnt_a_o <= inc(cnt_a_o);
      if (valid_i && v_blame[1]) cnt_b_o <= inc(cnt_b_o);
      if (valid_i && v_blame[2]) cnt_c_o <= inc(cnt_c_o);
      if (valid_i && v_multi) cnt_multi_o <= inc(cnt_multi_o);
      alarm_o <= alarm_o | hit;
    end
  end
`ifdef TMR_WORD_VOTER_OUT_REG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o        <= '0;
      valid_o       <= 1'b0;
      fault_o       <= 1'b0;
      blame_o       <= BLAME_NONE;
      multi_fault_o <= 1'b0;
    end else begin
      data_o        <= v_data;
      valid_o       <= valid_i;
      fault_o       <= valid_i & v_fault;
      blame_o       <= valid_i ? v_blame : BLAME_NONE;
      multi_fault_o <= valid_i & v_multi;
    end
  end
`else
  assign data_o        = v_data;
  assign valid_o       = valid_i;
  assign fault_o       = valid_i & v_fault;
  assign blame_o       = valid_i ? v_blame : BLAME_NONE;
  assign multi_fault_o = valid_i & v_multi;
`endif
endmodule
